// File: rtl/counter_driver_pkg.sv
// counter_drv_pkg: shared types for the counter driver.
//   op_e    - command opcodes carried on cmd_op (NOP/LOAD/UP/DOWN)
//   state_e - driver FSM states
package counter_drv_pkg;

  localparam logic [1:0] OPC_NOP  = 2'd0;
  localparam logic [1:0] OPC_LOAD = 2'd1;
  localparam logic [1:0] OPC_UP   = 2'd2;
  localparam logic [1:0] OPC_DOWN = 2'd3;

  typedef enum logic [1:0] {
    OP_NOP  = OPC_NOP,
    OP_LOAD = OPC_LOAD,
    OP_UP   = OPC_UP,
    OP_DOWN = OPC_DOWN
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_SETTLE
  } state_e;

endpackage

// File: rtl/counter_driver_if.sv
// counter_driver_if: command handshake between the test sequencer and the
// counter driver.
//   cmd_valid - command offered (sequencer -> driver)
//   cmd_ready - driver can accept a command (driver -> sequencer)
//   cmd_op    - opcode, see counter_drv_pkg::op_e
//   cmd_value - load value or step count
interface counter_driver_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_value;

  modport master (output cmd_valid, output cmd_op, output cmd_value, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_value, output cmd_ready);
endinterface

// File: rtl/counter_driver_model.sv
// counter_model: expected-count register for the up/down counter.
//   clk, rst                     - clock, synchronous active-high reset
//   ld_cnt, count_enb, updn_cnt  - the same controls the counter sees
//   data_in                      - load data
//   exp_count                    - expected counter value (wraps mod 2^WIDTH)
module counter_model #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_cnt,
  input  logic             count_enb,
  input  logic             updn_cnt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] exp_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_count <= '0;
    end else if (ld_cnt) begin
      exp_count <= data_in;
    end else if (count_enb) begin
      // natural WIDTH-bit wrap in both directions
      exp_count <= updn_cnt ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_driver.sv
// counter_driver: command-driven initiator for the up/down counter.
//   clk, rst   - clock, synchronous active-high reset
//   cmd        - command handshake (slave side)
//   data_in, ld_cnt, updn_cnt, count_enb - counter control outputs (registered)
//   data_out   - counter value, checked every cycle against exp_count
//   exp_count  - expected count from the internal model
//   done       - one-cycle pulse at command completion
//   err        - sticky mismatch flag; err_cnt - saturating mismatch count
module counter_driver
  import counter_drv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_driver_if.slave  cmd,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] exp_count,
  output logic             done,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  state_e           state, state_next;
  op_e              op_q, op_next;
  logic [WIDTH-1:0] value_q, value_next;

  logic             ld_next, enb_next, updn_next, done_next;
  logic [WIDTH-1:0] data_in_next;

  assign cmd.cmd_ready = (state == S_IDLE);

  // Controls are registered from the next state so they are valid during
  // the cycle the FSM sits in that state (e.g. ld_cnt high throughout LOAD).
  always_comb begin
    state_next = state;
    op_next    = op_q;
    value_next = value_q;
    case (state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_next    = op_e'(cmd.cmd_op);
          value_next = cmd.cmd_value;
          case (op_e'(cmd.cmd_op))
            OP_LOAD:        state_next = S_LOAD;
            OP_UP, OP_DOWN: state_next = (cmd.cmd_value != '0) ? S_COUNT : S_SETTLE;
            default:        state_next = S_SETTLE;
          endcase
        end
      end
      S_LOAD:  state_next = S_SETTLE;
      S_COUNT: begin
        // value_q is the number of enabled cycles still to go, including this one
        value_next = value_q - WIDTH'(1);
        if (value_q == WIDTH'(1)) state_next = S_SETTLE;
      end
      S_SETTLE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    ld_next      = (state_next == S_LOAD);
    enb_next     = (state_next == S_COUNT);
    done_next    = (state_next == S_SETTLE);
    data_in_next = (state_next == S_LOAD) ? value_next : '0;
    updn_next    = (state_next == S_COUNT) ? (op_next == OP_UP) : updn_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      value_q   <= '0;
      ld_cnt    <= 1'b0;
      count_enb <= 1'b0;
      updn_cnt  <= 1'b0;
      data_in   <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      value_q   <= value_next;
      ld_cnt    <= ld_next;
      count_enb <= enb_next;
      updn_cnt  <= updn_next;
      data_in   <= data_in_next;
      done      <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (data_out != exp_count) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
    end
  end

  counter_model #(.WIDTH(WIDTH)) u_model (
    .clk       (clk),
    .rst       (rst),
    .ld_cnt    (ld_cnt),
    .count_enb (count_enb),
    .updn_cnt  (updn_cnt),
    .data_in   (data_in),
    .exp_count (exp_count)
  );

endmodule

// File: tb/tb_counter_driver.sv
module tb_counter_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, data_out, exp_count;
  logic       ld_cnt, updn_cnt, count_enb, done, err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // behavioural reference: command-level expected count and direction
  int model_count = 0;
  logic last_dir = 1'b0;

  // stand-in counter with fault override
  logic [7:0] cnt;
  logic       fault_en = 1'b0;
  logic [7:0] fault_val = 8'h00;

  counter_driver_if #(.WIDTH(8)) cif ();

  counter_driver #(.WIDTH(8), .ERRW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_out  (data_out),
    .exp_count (exp_count),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cnt <= 8'h00;
    else if (ld_cnt) cnt <= data_in;
    else if (count_enb) cnt <= updn_cnt ? cnt + 8'd1 : cnt - 8'd1;
  end

  always_comb data_out = fault_en ? fault_val : cnt;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld"}, ld_cnt, 0);
    chk({tag, "_enb"}, count_enb, 0);
    chk({tag, "_updn"}, updn_cnt, 0);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_exp"}, exp_count, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Issue one command and check its cycle-level behaviour and final value.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] v);
    int n = int'(v);
    int exp_done_at, exp_nld, exp_nenb, new_count;
    int cyc = 0, nld = 0, nenb = 0, done_at = -1;
    logic got = 1'b0;
    logic dir = (op == 2'd2);

    exp_nld = 0; exp_nenb = 0; exp_done_at = 0; new_count = model_count;
    case (op)
      2'd1: begin exp_nld = 1; exp_done_at = 1; new_count = n; end
      2'd2: begin exp_nenb = n; exp_done_at = n; new_count = (model_count + n) % 256; end
      2'd3: begin exp_nenb = n; exp_done_at = n; new_count = (model_count - n + 256) % 256; end
      default: ;
    endcase

    @(negedge clk);
    chk("ready_before_cmd", cif.cmd_ready, 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_value = v;
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = $urandom_range(0, 3);
    cif.cmd_value = $urandom_range(0, 255);

    while (!got && cyc < 400) begin
      if (ld_cnt) begin
        nld++;
        chk("load_data_in", data_in, v);
      end
      if (count_enb) begin
        nenb++;
        chk("count_dir", updn_cnt, dir);
      end
      if (done) begin
        got = 1'b1;
        done_at = cyc;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end

    if ((op == 2'd2 || op == 2'd3) && n > 0) last_dir = dir;
    model_count = new_count;

    chk("done_seen", got, 1);
    chk("done_latency", done_at, exp_done_at);
    chk("ld_cycles", nld, exp_nld);
    chk("enb_cycles", nenb, exp_nenb);
    chk("final_data_out", data_out, model_count);
    chk("final_exp_count", exp_count, model_count);
    chk("no_err", err, 0);
    chk("busy_at_done", cif.cmd_ready, 0);
    chk("updn_hold", updn_cnt, last_dir);
    chk("idle_data_in", data_in, 0);

    @(posedge clk);
    #1;
    chk("done_one_pulse", done, 0);
    chk("ready_after_done", cif.cmd_ready, 1);
  endtask

  initial begin
    int seen_done, seen_enb;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_value = 8'h00;
    rst = 1'b1;

    // reset held two cycles
    @(posedge clk); #1;
    chk_reset_outputs("rst1");
    @(posedge clk); #1;
    chk_reset_outputs("rst2");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", cif.cmd_ready, 1);
    chk("post_rst_exp", exp_count, 0);
    chk("post_rst_err", err, 0);

    // directed commands
    run_cmd(2'd1, 8'hA5);
    run_cmd(2'd1, 8'hFE);
    run_cmd(2'd2, 8'd3);
    chk("wrap_up_value", exp_count, 8'h01);
    run_cmd(2'd1, 8'h01);
    run_cmd(2'd3, 8'd2);
    chk("wrap_down_value", exp_count, 8'hFF);
    run_cmd(2'd2, 8'd0);
    run_cmd(2'd0, 8'h77);
    run_cmd(2'd3, 8'd0);

    // randomized commands
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [7:0] v;
      op = 2'($urandom_range(0, 3));
      v  = (op == 2'd1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      run_cmd(op, v);
    end

    // fault injection: counter reads 0 while the model expects 5
    run_cmd(2'd1, 8'h05);
    @(negedge clk);
    fault_en  = 1'b1;
    fault_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    fault_en = 1'b0;
    chk("fault_err", err, 1);
    chk("fault_err_cnt", err_cnt, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("fault_err_sticky", err, 1);
    chk("fault_err_cnt_hold", err_cnt, 3);

    // saturation of the mismatch counter
    @(negedge clk);
    fault_en = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    fault_en = 1'b0;
    chk("err_cnt_saturate", err_cnt, 255);
    chk("err_still_set", err, 1);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("rst_clear");
    @(negedge clk);
    rst = 1'b0;
    model_count = 0;
    last_dir = 1'b0;

    // reset during the 4th enabled cycle of UP 10
    run_cmd(2'd1, 8'h40);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd2;
    cif.cmd_value = 8'd10;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    chk("mid_first_enb", count_enb, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_fourth_enb", count_enb, 1);
    chk("mid_fourth_exp", exp_count, 8'h43);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst1");
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst2");
    @(negedge clk);
    rst = 1'b0;
    model_count = 0;
    last_dir = 1'b0;
    @(posedge clk); #1;
    chk("mid_ready", cif.cmd_ready, 1);
    chk("mid_exp_zero", exp_count, 0);
    seen_done = 0;
    seen_enb = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done++;
      if (count_enb) seen_enb++;
      @(posedge clk); #1;
    end
    chk("mid_no_done", seen_done, 0);
    chk("mid_no_enb", seen_enb, 0);
    chk("mid_idle_ready", cif.cmd_ready, 1);

    // driver still works after the aborted command
    run_cmd(2'd3, 8'd1);
    run_cmd(2'd2, 8'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
